isp_uart_host_tx: RTL and testbench



---
 rtl/isp_uart_pkg.sv | 19 +
 rtl/isp_uart_byte_fifo.sv | 55 +++++
 rtl/isp_uart_host_tx.sv | 170 +++++++++++++++++
 tb/tb_isp_uart_host_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_uart_pkg.sv
// Shared types and helpers for the ISP host-side UART transmitter.
// Parity support in the top is selected by ISP_UART_HOST_TX_PARITY_EN.
package isp_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int UART_DATA_BITS = 8;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/isp_uart_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; the head entry is read straight from the
// storage registers so it is valid on the same cycle the FIFO goes non-empty.
module isp_uart_byte_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        push_ok;
    logic        pop_ok;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, push_ok};
        rd_d = rd_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/isp_uart_host_tx.sv
// Host-side UART transmitter feeding the SoC isp_uart_rx pin: FIFO-buffered
// 8N1 frames, or 8E1 when ISP_UART_HOST_TX_PARITY_EN is defined.
//
//   state  | meaning
//   IDLE   | line high, pop next byte when the FIFO is non-empty
//   START  | start bit (low) for CLK_DIV cycles
//   DATA   | 8 data bits LSB first, CLK_DIV cycles each
//   PARITY | even parity bit (parity build only)
//   STOP   | stop bit (high) for CLK_DIV cycles
module isp_uart_host_tx
    import isp_uart_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               uart_tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_last;
    logic          pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
`ifdef ISP_UART_HOST_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    isp_uart_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .data_i  (in_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign uart_tx   = tx_q;
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef ISP_UART_HOST_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    state_d = START;
`ifdef ISP_UART_HOST_TX_PARITY_EN
                    par_d   = even_parity(fifo_head);
`endif
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef ISP_UART_HOST_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef ISP_UART_HOST_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Line level is derived from the next state so uart_tx changes on the
        // same edge as the state register and comes straight from a flop.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef ISP_UART_HOST_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef ISP_UART_HOST_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef ISP_UART_HOST_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_isp_uart_host_tx.sv
// Self-checking bench for isp_uart_host_tx: directed byte vectors plus
// latency, back-to-back, FIFO-full and mid-frame reset sequences.
module tb_isp_uart_host_tx;

    localparam int DIV = 16;
    localparam int AW  = 4;
`ifdef ISP_UART_HOST_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          uart_tx;
    logic          busy;
    logic [AW:0]   fifo_count;

    int checks;
    int failures;
    int cyc;

    logic [7:0] rx_q[$];
    logic       par_rx_q[$];
    int         start_q[$];

    isp_uart_host_tx #(
        .CLK_DIV (DIV),
        .FIFO_AW (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line decoder: samples each bit at its midpoint, counted on falling edges.
    initial begin : monitor
        bit        act;
        int        cnt;
        int        k;
        logic [7:0] sh;
        act = 1'b0;
        cnt = 0;
        sh  = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                act = 1'b0;
                continue;
            end
            if (!act) begin
                if (uart_tx == 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                cnt++;
            end
            if (act && (cnt % DIV) == DIV / 2) begin
                k = cnt / DIV;
                if (k == 0) begin
                    chk("mon_start_bit", {31'b0, uart_tx}, 32'd0);
                end else if (k <= 8) begin
                    sh[k-1] = uart_tx;
                end
`ifdef ISP_UART_HOST_TX_PARITY_EN
                if (k == 9) par_rx_q.push_back(uart_tx);
`endif
                if (k == NBITS - 1) begin
                    chk("mon_stop_bit", {31'b0, uart_tx}, 32'd1);
                    rx_q.push_back(sh);
                    act = 1'b0;
                end
            end
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        par_rx_q.delete();
        start_q.delete();
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    initial begin : test
        int n;
        int low_seen;
        bit saw_full;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'hA5, 1'b0};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h07, 1'b1};
        vecs[5] = '{8'h03, 1'b0};
        vecs[6] = '{8'h80, 1'b1};
        vecs[7] = '{8'h3C, 1'b0};

        #23;
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fifo_count", {27'b0, fifo_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Latency and bit timing of a single 0x55 frame.
        clear_mon();
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_edge1_tx", {31'b0, uart_tx}, 32'd1);
        chk("lat_edge1_count", {27'b0, fifo_count}, 32'd1);
        chk("lat_edge1_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("lat_edge2_tx", {31'b0, uart_tx}, 32'd0);
        chk("lat_edge2_count", {27'b0, fifo_count}, 32'd0);
        repeat (DIV - 1) @(posedge clk);
        #1;
        chk("start_end_tx", {31'b0, uart_tx}, 32'd0);
        @(posedge clk);
        #1;
        chk("bit0_tx", {31'b0, uart_tx}, 32'd1);
        repeat (DIV) @(posedge clk);
        #1;
        chk("bit1_tx", {31'b0, uart_tx}, 32'd0);
        wait_idle(2 * FRAME, n);
        chk("lat_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) chk("lat_rx_byte", {24'b0, rx_q[0]}, 32'h55);

        // Table vectors: one byte each, busy duration and decoded content.
        for (int i = 0; i < 8; i++) begin
            clear_mon();
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 0;
            while (busy && n < 2 * FRAME) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("vec%0d_busy_cycles", i), n, FRAME + 1);
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_rx_count", i), rx_q.size(), 32'd1);
            if (rx_q.size() > 0)
                chk($sformatf("vec%0d_rx_byte", i), {24'b0, rx_q[0]}, {24'b0, vecs[i].data});
`ifdef ISP_UART_HOST_TX_PARITY_EN
            if (par_rx_q.size() > 0)
                chk($sformatf("vec%0d_parity", i), {31'b0, par_rx_q[0]}, {31'b0, vecs[i].par});
            else
                chk($sformatf("vec%0d_parity_seen", i), par_rx_q.size(), 32'd1);
`endif
        end

        // Back-to-back: three pushes on consecutive edges.
        clear_mon();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1 in_data = 8'h00;
        @(posedge clk);
        #1 in_data = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_count_after_push", {27'b0, fifo_count}, 32'd2);
        wait_idle(5 * FRAME, n);
        chk("b2b_rx_count", rx_q.size(), 32'd3);
        if (rx_q.size() == 3) begin
            chk("b2b_byte0", {24'b0, rx_q[0]}, 32'hA5);
            chk("b2b_byte1", {24'b0, rx_q[1]}, 32'h00);
            chk("b2b_byte2", {24'b0, rx_q[2]}, 32'hFF);
        end
        if (start_q.size() == 3) begin
            chk("b2b_gap01", start_q[1] - start_q[0], FRAME + 1);
            chk("b2b_gap12", start_q[2] - start_q[1], FRAME + 1);
        end else begin
            chk("b2b_start_count", start_q.size(), 32'd3);
        end
        chk("b2b_final_count", {27'b0, fifo_count}, 32'd0);

        // Fill the FIFO with in_valid held high; 18 bytes, one popped at once.
        clear_mon();
        saw_full = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h20 + 8'(i);
            n = 0;
            while (!in_ready && n < 2 * FRAME) begin
                if (!saw_full) begin
                    saw_full = 1'b1;
                    chk("full_count", {27'b0, fifo_count}, 32'd16);
                    chk("full_at_byte", i, 32'd17);
                end
                @(negedge clk);
                n++;
            end
            chk($sformatf("fill%0d_ready_timeout", i), {31'b0, in_ready}, 32'd1);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        chk("full_seen", {31'b0, saw_full}, 32'd1);
        wait_idle(20 * FRAME, n);
        chk("fill_rx_count", rx_q.size(), 32'd18);
        for (int i = 0; i < 18; i++) begin
            if (i < rx_q.size())
                chk($sformatf("fill_byte%0d", i), {24'b0, rx_q[i]}, 32'h20 + i);
        end

        // Mid-frame reset with a second byte still queued.
        clear_mon();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(posedge clk);
        #1 in_data = 8'h99;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2 * DIV + DIV / 2 + 2) @(negedge clk);
        chk("pre_rst_tx_low", {31'b0, uart_tx}, 32'd0);
        chk("pre_rst_count", {27'b0, fifo_count}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_mid_count", {27'b0, fifo_count}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_mon();
        low_seen = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) low_seen++;
        end
        chk("post_rst_quiet", low_seen, 32'd0);
        chk("post_rst_rx", rx_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
